// File: rtl/sync_fifo_flags_if.sv
// Producer/consumer bundle for sync_fifo_flags: write and read handshakes, flush, and status.
// "master" is the side that talks to the FIFO; "slave" is the FIFO itself.
interface sync_fifo_flags_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             clr;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic [CW-1:0]    peak;
    logic             overflow;
    logic             underflow;

    modport master (
        output clr, wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, peak, overflow, underflow
    );

    modport slave (
        input  clr, wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, peak, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered or first-word-fall-through read, programmable
// almost-full/almost-empty thresholds, occupancy count, high-water mark and error pulses.
module sync_fifo_flags #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int REGOUT    = 1,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic               clk,
    input  logic               rst,
    sync_fifo_flags_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] AF_T   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_T   = CW'(AE_THRESH);
    localparam logic [CW-1:0] FULL_T = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic [CW-1:0] peak_reg, peak_next;
    logic          full_reg, empty_reg;
    logic          almost_full_reg, almost_empty_reg;
    logic          overflow_reg, underflow_reg;
    logic          flush;
    logic          wr_acc, rd_acc;

    // Acceptance uses the flags registered at the start of the cycle, so a full
    // FIFO rejects a write even when a read frees a slot in the same cycle.
    always_comb begin
        flush       = rst | bus.clr;
        wr_acc      = bus.wr_en && !full_reg  && !flush;
        rd_acc      = bus.rd_en && !empty_reg && !flush;
        wr_ptr_next = wr_acc ? wr_ptr_reg + AW'(1) : wr_ptr_reg;
        rd_ptr_next = rd_acc ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
        count_next  = count_reg + CW'(wr_acc) - CW'(rd_acc);
        peak_next   = (count_next > peak_reg) ? count_next : peak_reg;
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            peak_reg         <= '0;
            full_reg         <= 1'b0;
            empty_reg        <= 1'b1;
            almost_full_reg  <= 1'b0;
            almost_empty_reg <= 1'b1;
            overflow_reg     <= 1'b0;
            underflow_reg    <= 1'b0;
        end else begin
            wr_ptr_reg       <= wr_ptr_next;
            rd_ptr_reg       <= rd_ptr_next;
            count_reg        <= count_next;
            peak_reg         <= peak_next;
            full_reg         <= (count_next == FULL_T);
            empty_reg        <= (count_next == '0);
            almost_full_reg  <= (count_next >= AF_T);
            almost_empty_reg <= (count_next <= AE_T);
            overflow_reg     <= bus.wr_en && full_reg;
            underflow_reg    <= bus.rd_en && empty_reg;
        end
    end

    // Storage carries no reset so it maps onto RAM primitives.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_reg] <= bus.wr_data;
        end
    end

    generate
        if (REGOUT != 0) begin : g_regout
            logic [WIDTH-1:0] rd_data_reg;
            logic             rd_valid_reg;

            always_ff @(posedge clk) begin
                if (flush) begin
                    rd_data_reg  <= '0;
                    rd_valid_reg <= 1'b0;
                end else begin
                    rd_valid_reg <= rd_acc;
                    if (rd_acc) begin
                        rd_data_reg <= mem[rd_ptr_reg];
                    end
                end
            end

            assign bus.rd_data  = rd_data_reg;
            assign bus.rd_valid = rd_valid_reg;
        end else begin : g_fwft
            // Head word shown directly; forced to zero while empty so stale
            // memory never appears on the bus after a flush.
            assign bus.rd_data  = empty_reg ? '0 : mem[rd_ptr_reg];
            assign bus.rd_valid = !empty_reg;
        end
    endgenerate

    assign bus.full         = full_reg;
    assign bus.empty        = empty_reg;
    assign bus.almost_full  = almost_full_reg;
    assign bus.almost_empty = almost_empty_reg;
    assign bus.count        = count_reg;
    assign bus.peak         = peak_reg;
    assign bus.overflow     = overflow_reg;
    assign bus.underflow    = underflow_reg;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench for sync_fifo_flags: a registered-read instance driven cycle by cycle
// against a reference model, plus a first-word-fall-through instance with directed checks.
module tb_sync_fifo_flags;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sync_fifo_flags_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) mb ();
    sync_fifo_flags_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) fb ();

    sync_fifo_flags #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .REGOUT(1), .AF_THRESH(AF), .AE_THRESH(AE)
    ) u_dut (
        .clk(clk), .rst(rst), .bus(mb)
    );

    sync_fifo_flags #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .REGOUT(0), .AF_THRESH(AF), .AE_THRESH(AE)
    ) u_fwft (
        .clk(clk), .rst(rst), .bus(fb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] fifo_q [$];
    logic [7:0] sb_q [$];
    int         m_count = 0;
    int         m_peak  = 0;
    logic [7:0] m_hold  = '0;
    logic       exp_valid, exp_ovf, exp_unf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic wr, input logic [7:0] d, input logic rd,
                        input logic do_clr, input logic do_rst);
        logic wr_acc, rd_acc;
        logic [7:0] e;
        if (do_clr || do_rst) begin
            m_count = 0;
            m_peak  = 0;
            m_hold  = '0;
            fifo_q.delete();
            sb_q.delete();
            exp_valid = 1'b0;
            exp_ovf   = 1'b0;
            exp_unf   = 1'b0;
        end else begin
            wr_acc = wr && (m_count != DEPTH);
            rd_acc = rd && (m_count != 0);
            if (rd_acc) sb_q.push_back(fifo_q.pop_front());
            if (wr_acc) fifo_q.push_back(d);
            m_count   = m_count + int'(wr_acc) - int'(rd_acc);
            if (m_count > m_peak) m_peak = m_count;
            exp_valid = rd_acc;
            exp_ovf   = wr && !wr_acc;
            exp_unf   = rd && !rd_acc;
        end
        rst        = do_rst;
        mb.clr     = do_clr;
        mb.wr_en   = wr;
        mb.wr_data = d;
        mb.rd_en   = rd;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        mb.clr   = 1'b0;
        mb.wr_en = 1'b0;
        mb.rd_en = 1'b0;
        $display("[%0t] wr=%0b d=%02h rd=%0b clr=%0b rst=%0b -> cnt=%0d pk=%0d f=%0b e=%0b af=%0b ae=%0b ov=%0b un=%0b v=%0b q=%02h",
                 $time, wr, d, rd, do_clr, do_rst, mb.count, mb.peak, mb.full, mb.empty,
                 mb.almost_full, mb.almost_empty, mb.overflow, mb.underflow, mb.rd_valid, mb.rd_data);
        chk("count",        32'(mb.count),     32'(m_count));
        chk("peak",         32'(mb.peak),      32'(m_peak));
        chk("full",         32'(mb.full),      32'(m_count == DEPTH));
        chk("empty",        32'(mb.empty),     32'(m_count == 0));
        chk("almost_full",  32'(mb.almost_full),  32'(m_count >= AF));
        chk("almost_empty", 32'(mb.almost_empty), 32'(m_count <= AE));
        chk("overflow",     32'(mb.overflow),  32'(exp_ovf));
        chk("underflow",    32'(mb.underflow), 32'(exp_unf));
        chk("rd_valid",     32'(mb.rd_valid),  32'(exp_valid));
        if (mb.rd_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_nonempty", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk("rd_data", 32'(mb.rd_data), 32'(e));
                m_hold = e;
            end
        end else begin
            chk("rd_data_hold", 32'(mb.rd_data), 32'(m_hold));
        end
    endtask

    task automatic fcycle(input logic wr, input logic [7:0] d, input logic rd);
        fb.wr_en   = wr;
        fb.wr_data = d;
        fb.rd_en   = rd;
        @(posedge clk);
        #1;
        fb.wr_en = 1'b0;
        fb.rd_en = 1'b0;
        $display("[%0t] fwft wr=%0b d=%02h rd=%0b -> cnt=%0d e=%0b v=%0b q=%02h un=%0b",
                 $time, wr, d, rd, fb.count, fb.empty, fb.rd_valid, fb.rd_data, fb.underflow);
    endtask

    initial begin
        mb.clr = 1'b0; mb.wr_en = 1'b0; mb.wr_data = '0; mb.rd_en = 1'b0;
        fb.clr = 1'b0; fb.wr_en = 1'b0; fb.wr_data = '0; fb.rd_en = 1'b0;

        // Reset and fill to full, then one rejected write
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0, 0, 0);
        step(1, 8'hEE, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);

        // Drain in order, then one rejected read
        for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);

        // Steady state at count 8 across several pointer wraps
        for (int i = 0; i < 8; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
        for (int i = 0; i < 40; i++) step(1, 8'(8'h48 + i), 1, 0, 0);

        // Full with simultaneous write and read
        for (int i = 0; i < 8; i++) step(1, 8'(8'hA0 + i), 0, 0, 0);
        step(1, 8'hBB, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);

        // Flush mid-operation with count 9 / peak 12, write ignored
        step(0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 12; i++) step(1, 8'(8'h30 + i), 0, 0, 0);
        for (int i = 0; i < 3; i++)  step(0, 8'h00, 1, 0, 0);
        step(1, 8'hDD, 0, 1, 0);
        step(0, 8'h00, 0, 0, 0);
        step(1, 8'h5A, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);

        // Same scenario with rst
        for (int i = 0; i < 12; i++) step(1, 8'(8'h60 + i), 0, 0, 0);
        for (int i = 0; i < 3; i++)  step(0, 8'h00, 1, 0, 0);
        step(1, 8'hDD, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0);
        step(1, 8'h77, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);

        // First-word-fall-through instance
        fcycle(1, 8'hA5, 0);
        chk("fwft_valid", 32'(fb.rd_valid), 32'd1);
        chk("fwft_data",  32'(fb.rd_data),  32'hA5);
        chk("fwft_empty", 32'(fb.empty),    32'd0);
        fcycle(0, 8'h00, 0);
        chk("fwft_hold_valid", 32'(fb.rd_valid), 32'd1);
        chk("fwft_hold_data",  32'(fb.rd_data),  32'hA5);
        fcycle(0, 8'h00, 1);
        chk("fwft_pop_empty", 32'(fb.empty),    32'd1);
        chk("fwft_pop_valid", 32'(fb.rd_valid), 32'd0);
        chk("fwft_pop_count", 32'(fb.count),    32'd0);
        chk("fwft_pop_unf",   32'(fb.underflow), 32'd0);
        fcycle(0, 8'h00, 1);
        chk("fwft_underflow", 32'(fb.underflow), 32'd1);
        fcycle(1, 8'h11, 0);
        chk("fwft_unf_clear", 32'(fb.underflow), 32'd0);
        fcycle(1, 8'h22, 0);
        chk("fwft_head1", 32'(fb.rd_data), 32'h11);
        fcycle(0, 8'h00, 1);
        chk("fwft_head2", 32'(fb.rd_data), 32'h22);
        chk("fwft_count", 32'(fb.count),   32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Parametrised single-clock FIFO, successor to the team's generic synchronous FIFO. Adds a selectable read mode (registered read or first-word-fall-through), programmable almost-full/almost-empty thresholds, an occupancy count with a high-water mark, and single-cycle overflow/underflow error pulses. Sits between same-clock producer/consumer blocks and is the standard buffer for new datapaths.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥4
- REGOUT, 1, 1 = registered read (1-cycle latency); 0 = first-word-fall-through (FWFT)
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserts when count ≤ AE_THRESH (0..DEPTH-1)
- Derived: CW = $clog2(DEPTH+1)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- clr  in  1  synchronous flush; same effect as rst on FIFO state
- wr_en  in  1  write request
- wr_data  in  WIDTH  write data
- rd_en  in  1  read request
- rd_data  out  WIDTH  read data
- rd_valid  out  1  rd_data holds a valid popped/head word
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- count  out  CW  current occupancy, 0..DEPTH
- peak  out  CW  maximum count since last rst/clr
- overflow  out  1  one-cycle pulse: rejected write
- underflow  out  1  one-cycle pulse: rejected read

## Operation
- Storage: DEPTH×WIDTH array, write and read pointers of log2(DEPTH) bits, wrapping naturally from DEPTH-1 to 0.
- Write accepted iff wr_en && !full; read accepted iff rd_en && !empty. Flags are evaluated as registered at the start of the cycle.
- Both accepted in the same cycle: both pointers advance and count is unchanged. This holds for any non-empty, non-full occupancy.
- Full with wr_en && rd_en: read accepted, write rejected (overflow pulses); count goes to DEPTH-1.
- Empty with wr_en && rd_en: write accepted, read rejected (underflow pulses); count goes to 1.
- count_next = count + wr_acc − rd_acc.
- full, empty, almost_full and almost_empty are registered and computed from count_next.
- peak_next = max(peak, count_next).
- overflow and underflow are registered and assert the cycle after the offending request, for one cycle per offending request.
- REGOUT=1:
  - rd_data loads mem[rd_ptr] on an accepted read and is held otherwise.
  - rd_valid is high exactly in the cycle after an accepted read.
- REGOUT=0 (FWFT):
  - rd_data = mem[rd_ptr] combinationally; rd_valid = !empty.
  - rd_en pops the displayed word.
- Priority: rst > clr > wr/rd. During a rst or clr cycle, wr_en and rd_en are ignored and no error pulses are generated.
- rst/clr return every output to its reset value. Memory contents are not cleared.
- Reset values: rd_data=0, rd_valid=0, full=0, empty=1, almost_full=0, almost_empty=1, count=0, peak=0, overflow=0, underflow=0.

## Timing
- Write-to-visible:
  - A word written into an empty FIFO at edge N sets empty=0 after edge N.
  - REGOUT=0: the word appears on rd_data in cycle N+1.
  - REGOUT=1: the earliest accepted read is in cycle N+1, and its data appears in cycle N+2.
- Read latency: 1 cycle for REGOUT=1, 0 cycles for REGOUT=0.
- All flags, count and peak change only on clk edges, one cycle after the causing request.
- Throughput: one write and one read per cycle, sustained indefinitely with no bubbles at pointer wrap.

## Test plan
- **Reset/fill** (DEPTH=16, AF=14, AE=2): after rst, write 0x00..0x0F on consecutive cycles.
  - Required: count reaches 16.
  - almost_empty drops when count becomes 3; almost_full rises at count 14; full rises at count 16.
  - peak=16. A 17th write pulses overflow once, and count stays 16.
- **Drain ordering, REGOUT=1**: read 16 times back-to-back.
  - Required: rd_data = 0x00..0x0F in order, each one cycle after its rd_en.
  - empty=1 after the last read. One extra rd_en pulses underflow, and rd_valid stays 0.
- **FWFT, REGOUT=0**: a single write of 0xA5 into the empty FIFO.
  - Required: the next cycle shows rd_data=0xA5, rd_valid=1 with no rd_en issued.
  - Asserting rd_en pops it, then empty=1 and rd_valid=0.
- **Simultaneous ops / wrap**: hold count=8 with wr_en=rd_en=1 for 40 cycles, writing an incrementing pattern.
  - Required: count stays 8 throughout and flags do not toggle.
  - Read data matches the written sequence across multiple pointer wraps.
- **Full + both**: at count=16, assert wr_en=rd_en=1.
  - Required: the read succeeds, overflow pulses, and count=15.
- **Mid-operation clr/rst**: with count=9 and peak=12, assert clr for one cycle together with wr_en=1.
  - Required: next cycle count=0, peak=0, empty=1, no write stored, and no error pulse.
  - Repeat with rst for the same result, including rd_data=0.
